// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one transaction in flight. Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no access in flight; grant is combinational from the requests
// WAIT  | memory signals driven; latency counter runs up to MEM_LATENCY
// RESP  | owner's rvalid pulse; no grant this cycle
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DWIDTH-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [1:0]        d_size_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [1:0]        mem_size_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    logic [3:0] lat_cnt;
    logic       owner_d;
    logic       force_i;
    logic       gnt_i;
    logic       gnt_d;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY out of range 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT out of range 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_i = i_req_i && d_req_i && (starve_cnt == 4'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (gnt_i) begin
            starve_cnt <= 4'd0;
        end else if (gnt_d) begin
            starve_cnt <= i_req_i ? starve_cnt + 4'd1 : 4'd0;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    assign gnt_d   = (state == IDLE) && d_req_i && !force_i;
    assign gnt_i   = (state == IDLE) && i_req_i && (!d_req_i || force_i);
    // Reset masks the combinational grants so every output is 0 during rst.
    assign d_gnt_o = gnt_d && !rst;
    assign i_gnt_o = gnt_i && !rst;
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= 4'd0;
            owner_d        <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            mem_size_o     <= 2'b00;
            mem_read_en_o  <= 1'b0;
            mem_write_en_o <= 1'b0;
            i_rvalid_o     <= 1'b0;
            d_rvalid_o     <= 1'b0;
            i_rdata_o      <= '0;
            d_rdata_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_d) begin
                        state          <= WAIT;
                        lat_cnt        <= 4'd1;
                        owner_d        <= 1'b1;
                        mem_addr_o     <= d_addr_i;
                        mem_wdata_o    <= d_wdata_i;
                        mem_size_o     <= d_size_i;
                        mem_read_en_o  <= !d_we_i;
                        mem_write_en_o <= d_we_i;
                    end else if (gnt_i) begin
                        state          <= WAIT;
                        lat_cnt        <= 4'd1;
                        owner_d        <= 1'b0;
                        mem_addr_o     <= i_addr_i;
                        mem_wdata_o    <= '0;
                        mem_size_o     <= 2'b10;
                        mem_read_en_o  <= 1'b1;
                        mem_write_en_o <= 1'b0;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'(MEM_LATENCY)) begin
                        state          <= RESP;
                        lat_cnt        <= 4'd0;
                        mem_addr_o     <= '0;
                        mem_wdata_o    <= '0;
                        mem_size_o     <= 2'b00;
                        mem_read_en_o  <= 1'b0;
                        mem_write_en_o <= 1'b0;
                        if (owner_d) begin
                            d_rvalid_o <= 1'b1;
                            d_rdata_o  <= mem_write_en_o ? '0 : mem_rdata_i;
                        end else begin
                            i_rvalid_o <= 1'b1;
                            i_rdata_o  <= mem_rdata_i;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    i_rvalid_o <= 1'b0;
                    d_rvalid_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut1 (MEM_LATENCY=1) and dut3
// (MEM_LATENCY=3) share stimulus; expected values are hand-computed.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] mem_rdata = '0;

    logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, rd_en1, wr_en1, busy1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic [1:0]  mem_size1;
    logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, rd_en3, wr_en3, busy3;
    logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic [1:0]  mem_size3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt1),
        .i_rvalid_o(i_rvalid1), .i_rdata_o(i_rdata1),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_size_i(d_size), .d_gnt_o(d_gnt1), .d_rvalid_o(d_rvalid1), .d_rdata_o(d_rdata1),
        .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_size_o(mem_size1),
        .mem_read_en_o(rd_en1), .mem_write_en_o(wr_en1), .mem_rdata_i(mem_rdata),
        .busy_o(busy1)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt3),
        .i_rvalid_o(i_rvalid3), .i_rdata_o(i_rdata3),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_size_i(d_size), .d_gnt_o(d_gnt3), .d_rvalid_o(d_rvalid3), .d_rdata_o(d_rdata3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_size_o(mem_size3),
        .mem_read_en_o(rd_en3), .mem_write_en_o(wr_en3), .mem_rdata_i(mem_rdata),
        .busy_o(busy3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs are driven just after the rising edge; checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [7:0] grants [10];
    logic [7:0] exp_g;
    int         ng;

    initial begin
        // reset state
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_busy",   64'(busy1), 64'(0));
        check("rst_mem_rd", 64'(rd_en1), 64'(0));
        check("rst_rvalid", 64'({i_rvalid1, d_rvalid1}), 64'(0));
        check("rst_rdata",  64'({i_rdata1, d_rdata1}), 64'(0));
        check("rst_memaddr", 64'(mem_addr1), 64'(0));
        rst = 1'b0;
        tick();

        // fetch-only, latency 1
        i_req = 1'b1; i_addr = 32'h0100_0000;
        #1;
        check("f_gnt_c0", 64'({i_gnt1, d_gnt1}), 64'(2'b10));
        tick();
        i_req = 1'b0; mem_rdata = 32'h0000_0013;
        #1;
        check("f_rd_c1",   64'({rd_en1, wr_en1}), 64'(2'b10));
        check("f_addr_c1", 64'(mem_addr1), 64'(32'h0100_0000));
        check("f_size_c1", 64'(mem_size1), 64'(2'b10));
        check("f_busy_c1", 64'(busy1), 64'(1));
        tick();
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("f_rvalid_c2", 64'(i_rvalid1), 64'(1));
        check("f_rdata_c2",  64'(i_rdata1), 64'(32'h0000_0013));
        check("f_memrd_c2",  64'(rd_en1), 64'(0));
        tick();
        #1;
        check("f_busy_c3",   64'({busy1, i_rvalid1}), 64'(0));
        check("f_rdhold_c3", 64'(i_rdata1), 64'(32'h0000_0013));

        // simultaneous requests: data first
        i_req = 1'b1; i_addr = 32'h0100_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0200_0000; d_size = 2'b10;
        #1;
        check("s_gnt_c0", 64'({i_gnt1, d_gnt1}), 64'(2'b01));
        tick();
        d_req = 1'b0; mem_rdata = 32'hA5A5_0001;
        #1;
        check("s_daddr_c1", 64'(mem_addr1), 64'(32'h0200_0000));
        check("s_gnt_c1",   64'({i_gnt1, d_gnt1}), 64'(0));
        tick();
        #1;
        check("s_dvalid_c2", 64'({d_rvalid1, i_gnt1}), 64'(2'b10));
        check("s_drdata_c2", 64'(d_rdata1), 64'(32'hA5A5_0001));
        tick();
        #1;
        check("s_igLt_c3", 64'({i_gnt1, d_gnt1}), 64'(2'b10));
        tick();
        i_req = 1'b0; mem_rdata = 32'h0000_0297;
        #1;
        check("s_iaddr_c4", 64'(mem_addr1), 64'(32'h0100_0004));
        check("s_iwd_c4",   64'({mem_wdata1, rd_en1}), 64'({32'h0, 1'b1}));
        tick();
        #1;
        check("s_ivalid_c5", 64'(i_rvalid1), 64'(1));
        check("s_irdata_c5", 64'(i_rdata1), 64'(32'h0000_0297));
        check("s_dhold_c5",  64'(d_rdata1), 64'(32'hA5A5_0001));
        tick();

        // store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0200_0010;
        d_wdata = 32'hDEAD_BEEF; d_size = 2'b10;
        #1;
        check("w_gnt_c0", 64'(d_gnt1), 64'(1));
        tick();
        d_req = 1'b0; mem_rdata = 32'h1234_5678;
        #1;
        check("w_en_c1",    64'({rd_en1, wr_en1}), 64'(2'b01));
        check("w_addr_c1",  64'(mem_addr1), 64'(32'h0200_0010));
        check("w_wdata_c1", 64'(mem_wdata1), 64'(32'hDEAD_BEEF));
        check("w_size_c1",  64'(mem_size1), 64'(2'b10));
        tick();
        #1;
        check("w_rvalid_c2", 64'(d_rvalid1), 64'(1));
        check("w_rdata_c2",  64'(d_rdata1), 64'(0));
        check("w_wren_c2",   64'(wr_en1), 64'(0));
        d_we = 1'b0;

        // latency 3 load on dut3
        do_reset();
        d_req = 1'b1; d_addr = 32'h0200_0020; d_size = 2'b01;
        #1;
        check("l3_gnt_c0", 64'(d_gnt3), 64'(1));
        for (int c = 1; c <= 3; c++) begin
            tick();
            d_req = 1'b0;
            mem_rdata = 32'(c) * 32'h111;
            #1;
            check("l3_rd_hold", 64'({rd_en3, d_rvalid3, busy3}), 64'(3'b101));
        end
        tick();
        mem_rdata = 32'h0;
        #1;
        check("l3_rvalid_c4", 64'(d_rvalid3), 64'(1));
        check("l3_rdata_c4",  64'(d_rdata3), 64'(32'h333));
        check("l3_rd_c4",     64'(rd_en3), 64'(0));

        // reset during WAIT
        do_reset();
        d_req = 1'b1; d_addr = 32'h0200_0030;
        #1;
        check("r_gnt_c0", 64'(d_gnt1), 64'(1));
        tick();
        d_req = 1'b0;
        #1;
        check("r_wait_c1", 64'(rd_en1), 64'(1));
        rst = 1'b1;
        d_req = 1'b1;
        #1;
        check("r_async_out", 64'({rd_en1, busy1, d_gnt1, i_gnt1, d_rvalid1}), 64'(0));
        check("r_async_addr", 64'(mem_addr1), 64'(0));
        tick();
        check("r_no_rvalid", 64'({d_rvalid1, busy1}), 64'(0));
        rst = 1'b0;
        #1;
        check("r_first_gnt", 64'(d_gnt1), 64'(1));
        tick();
        d_req = 1'b0;
        #1;
        check("r_regrant_wait", 64'(rd_en1), 64'(1));
        tick();
        tick();

        // arbitration order with both requests held
        do_reset();
        i_req = 1'b1; i_addr = 32'h0100_0100;
        d_req = 1'b1; d_addr = 32'h0200_0100;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            #1;
            if (i_gnt1 || d_gnt1) begin
                check("st_onehot", 64'(i_gnt1 && d_gnt1), 64'(0));
                grants[ng] = d_gnt1 ? 8'h44 : 8'h49;
                ng++;
            end
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        check("st_count", 64'(ng), 64'(10));
        for (int k = 0; k < 10 && k < ng; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_g = (k % 5 == 4) ? 8'h49 : 8'h44;
`else
            exp_g = 8'h44;
`endif
            check("st_order", 64'(grants[k]), 64'(exp_g));
        end
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). This lets the core run from one unified memory model instead of separate imem/dmem instances.
- Sits between the fetch/memory stages and the `memory` instance.
- Arbitrates requests, sequences each access over a fixed memory latency and routes the response back to its owner.
- Exactly one transaction is outstanding at any time.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- MEM_LATENCY, 1, cycles that memory signals are held before read data is sampled; legal range 1..15.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting (used only with the optional feature); legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req_i  in  1  fetch request; held high with address stable until i_gnt_o.
- i_addr_i  in  AWIDTH  fetch address.
- i_gnt_o  out  1  fetch request accepted this cycle.
- i_rvalid_o  out  1  one-cycle pulse: i_rdata_o valid.
- i_rdata_o  out  DWIDTH  instruction word.
- d_req_i  in  1  data request; held high until d_gnt_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  AWIDTH  data address.
- d_wdata_i  in  DWIDTH  store data.
- d_size_i  in  2  funct3[1:0] size encoding, passed through.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata_o  out  DWIDTH  load data; 0 for stores.
- mem_addr_o  out  AWIDTH  memory address.
- mem_wdata_o  out  DWIDTH  memory write data.
- mem_size_o  out  2  access size.
- mem_read_en_o  out  1  memory read enable.
- mem_write_en_o  out  1  memory write enable.
- mem_rdata_i  in  DWIDTH  memory read data.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0, state goes to IDLE, counters clear.
  - An in-flight transaction is dropped and produces no rvalid pulse.
  - First grant is possible in the first cycle after rst deasserts.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If any request is high, exactly one gnt_o is driven high in that same cycle (combinational from the req inputs).
  - At the clock edge, owner/addr/wdata/we/size are latched, the latency counter loads 1, and the state goes to WAIT.
  - No request: remain in IDLE.
- Priority (default): data over fetch. Both requests high means d_gnt_o = 1 and i_gnt_o = 0.
- WAIT:
  - mem_addr_o, mem_wdata_o and mem_size_o are driven from the latched registers.
  - Data-owned access: mem_read_en_o = !we, mem_write_en_o = we.
  - Fetch-owned access: mem_read_en_o = 1, mem_write_en_o = 0; mem_wdata_o = 0 and mem_size_o = 2'b10.
  - Counter increments each cycle.
  - When counter == MEM_LATENCY: mem_rdata_i is captured into the owner's rdata register and the state goes to RESP.
- RESP:
  - The owner's rvalid_o is high for exactly one cycle; no grant is issued; next state is IDLE.
  - rdata_o holds its value until the next response to that same owner.
  - Data store response: d_rdata_o = 0.
- Timing: grant in cycle T; memory signals active in cycles T+1 .. T+MEM_LATENCY; rvalid in cycle T+MEM_LATENCY+1; next grant possible at T+MEM_LATENCY+2.
- Outside WAIT, all mem_* outputs are 0.
- gnt_o outside IDLE: always 0. Requests arriving while busy are held by the requester and are not lost.
- Request dropped before grant: legal; nothing is latched.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined, a starvation counter (width 4) applies:
  - Increments on each data grant made while i_req_i is high.
  - Clears on any fetch grant, and on a data grant made while i_req_i is low.
  - If both requests are high and the counter == STARVE_LIMIT, fetch is granted instead of data, and the counter clears.
- When undefined: strict data priority; the counter logic is absent.

Test Plan:
- MEM_LATENCY=1; fetch-only request, addr 0x01000000, memory returns 0x00000013 → i_gnt_o in cycle 0; mem_read_en_o high in cycle 1; i_rvalid_o with i_rdata_o = 0x00000013 in cycle 2; busy_o low in cycle 3.
- Simultaneous requests: fetch 0x01000004 and data load 0x02000000 → d_gnt_o first; d_rvalid_o in cycle 2; i_gnt_o in cycle 3; i_rvalid_o in cycle 5.
- Store: d_we_i=1, addr 0x02000010, wdata 0xDEADBEEF, size 2'b10 → mem_write_en_o=1 and mem_read_en_o=0 for MEM_LATENCY cycles; d_rvalid_o pulses with d_rdata_o = 0.
- MEM_LATENCY=3; data load → memory signals held exactly 3 cycles; d_rvalid_o in cycle 4 carries the mem_rdata_i value from cycle 3.
- Assert rst during WAIT → all outputs 0 immediately (asynchronously); no rvalid pulse follows; a pending request is granted in the first cycle after rst deasserts.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4; both requests held continuously → grant order D,D,D,D,I, then repeating. Without the macro, only D grants occur.
